jtag_host: RTL and testbench

//  On-chip JTAG initiator: generates tck/tms/tdi from sysclk and captures tdo.

---
 rtl/jtag_host_if.sv | 24 ++
 rtl/jtag_host.sv | 175 +++++++++++++++++
 tb/tb_jtag_host.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_host_if.sv
// Command/response bundle between a JTAG host and the logic that drives it.
interface jtag_host_if #(
  parameter int MAX_LEN = 192,
  parameter int LEN_W   = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_host.sv
// On-chip JTAG initiator: runs RESET, IR-scan and DR-scan commands against a
// 1149.1 TAP, generating tck/tms/tdi from sysclk and capturing tdo.
module jtag_host #(
  parameter int CLKDIV  = 4,
  parameter int MAX_LEN = 192,
  parameter int LEN_W   = 8
) (
  input  logic       sysclk,
  input  logic       trst,
  jtag_host_if.slave bus,
  output logic       busy,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  input  logic       tdo
);
  localparam int CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BIT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] LAST_MAX = BIT_W'(MAX_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;
  typedef enum logic [1:0] {OP_RESET, OP_IR, OP_DR} op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d, cmd_op;
  logic [BIT_W-1:0]   bit_q, bit_d, last_q, last_d, cmd_last, pre_last;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [MAX_LEN-1:0] data_q, data_d, rsp_q, rsp_d;
  logic [IDX_W-1:0]   idx;
  logic               tick, fall, rise, bit_tms;

  assign tick = (cnt_q == '0);
  assign fall = tick & tck_q;
  assign rise = tick & ~tck_q;
  assign idx  = bit_q[IDX_W-1:0];

  assign busy          = (state_q == S_PRE) || (state_q == S_SHIFT) || (state_q == S_POST);
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_q;
  assign tck           = tck_q;
  assign tms           = tms_q;
  assign tdi           = tdi_q;

  // Decode the offered command: reserved type behaves as RESET, length clamps to MAX_LEN.
  always_comb begin
    case (bus.cmd_type)
      2'd1:    cmd_op = OP_IR;
      2'd2:    cmd_op = OP_DR;
      default: cmd_op = OP_RESET;
    endcase
    cmd_last = ({1'b0, bus.cmd_len} > LAST_MAX) ? LAST_MAX : {1'b0, bus.cmd_len};
  end

  // TMS value of the bit currently addressed by state_q/bit_q, and the preamble length.
  always_comb begin
    case (op_q)
      OP_IR:   pre_last = BIT_W'(3);
      OP_DR:   pre_last = BIT_W'(2);
      default: pre_last = BIT_W'(5);
    endcase
    bit_tms = 1'b0;
    case (state_q)
      S_PRE: begin
        case (op_q)
          OP_IR:   bit_tms = (bit_q < BIT_W'(2));
          OP_DR:   bit_tms = (bit_q == '0);
          default: bit_tms = (bit_q < BIT_W'(5));
        endcase
      end
      S_SHIFT: bit_tms = (bit_q == last_q);
      S_POST:  bit_tms = (bit_q == '0);
      default: bit_tms = 1'b0;
    endcase
  end

  // Next state: tck divider, drive on tck fall, sample and advance on tck rise.
  // state_q/bit_q name the bit being presented; it is driven at the fall and
  // retired at the following rise, so the final rise lands directly in S_RESP.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bit_d   = bit_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_PRE;
          op_d    = cmd_op;
          last_d  = cmd_last;
          bit_d   = '0;
          cnt_d   = CNT_LOAD;
          data_d  = bus.cmd_data;
          rsp_d   = '0;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: begin
        cnt_d = tick ? CNT_LOAD : cnt_q - 1'b1;
        if (tick) tck_d = ~tck_q;
        if (fall) begin
          tms_d = bit_tms;
          tdi_d = (state_q == S_SHIFT) ? data_q[idx] : 1'b1;
        end
        if (rise) begin
          if (state_q == S_SHIFT) rsp_d[idx] = tdo;
          case (state_q)
            S_PRE: begin
              if (bit_q == pre_last) begin
                bit_d   = '0;
                state_d = (op_q == OP_RESET) ? S_RESP : S_SHIFT;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
            S_SHIFT: begin
              if (bit_q == last_q) begin
                bit_d   = '0;
                state_d = S_POST;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
            default: begin
              if (bit_q != '0) state_d = S_RESP;
              else             bit_d   = bit_q + 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge sysclk or negedge trst) begin
    if (!trst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: divider, JTAG pins, command and capture storage.
  always_ff @(posedge sysclk or negedge trst) begin
    if (!trst) begin
      op_q   <= OP_RESET;
      bit_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      tck_q  <= 1'b1;
      tms_q  <= 1'b1;
      tdi_q  <= 1'b1;
      data_q <= '0;
      rsp_q  <= '0;
    end else begin
      op_q   <= op_d;
      bit_q  <= bit_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      tck_q  <= tck_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
      data_q <= data_d;
      rsp_q  <= rsp_d;
    end
  end
endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: a 1149.1 TAP model (4-bit IR, 162-bit
// boundary chain behind SAMPLE) plus a tdi->tdo loopback path.
module tb_jtag_host;
  logic sysclk = 1'b0;
  logic trst   = 1'b1;
  logic busy, tck, tms, tdi, tdo;
  bit   loopback = 1'b0;

  jtag_host_if #(.MAX_LEN(192), .LEN_W(8)) bus ();

  jtag_host #(.CLKDIV(4), .MAX_LEN(192), .LEN_W(8)) dut (
    .sysclk (sysclk),
    .trst   (trst),
    .bus    (bus),
    .busy   (busy),
    .tck    (tck),
    .tms    (tms),
    .tdi    (tdi),
    .tdo    (tdo)
  );

  always #5 sysclk = ~sysclk;

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  localparam logic [3:0] SAMPLE = 4'b0010;
  localparam logic [3:0] BYPASS = 4'b1111;

  tap_t         tap_st;
  logic [3:0]   ir, ir_sr;
  logic [161:0] dr_sr, bnd_cap;
  logic         tap_tdo;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_st <= TLR;
      ir     <= BYPASS;
    end else begin
      case (tap_st)
        TLR:   ir <= BYPASS;
        CAPIR: ir_sr <= 4'b0001;
        SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
        UPIR:  ir <= ir_sr;
        CAPDR: dr_sr <= (ir == SAMPLE) ? bnd_cap : '0;
        SHDR:  if (ir == SAMPLE) dr_sr <= {tdi, dr_sr[161:1]};
               else              dr_sr[0] <= tdi;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck)
    tap_tdo <= (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;

  assign tdo = loopback ? tdi : tap_tdo;

  // ---------------- edge monitor ----------------
  int   cyc = 0, acc_cyc = 0, rise_total = 0, fall_total = 0;
  int   rise_cyc [0:1023];
  int   fall_cyc [0:1023];
  logic tms_log  [0:1023];
  logic tdi_log  [0:1023];
  logic tck_prev = 1'b1;

  always @(negedge sysclk) begin
    if (tck_prev && !tck && fall_total < 1024) begin
      fall_cyc[fall_total] = cyc;
      fall_total++;
    end
    if (!tck_prev && tck && trst && rise_total < 1024) begin
      rise_cyc[rise_total] = cyc;
      tms_log[rise_total]  = tms;
      tdi_log[rise_total]  = tdi;
      rise_total++;
    end
    tck_prev = tck;
    cyc++;
  end

  always @(posedge sysclk)
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;

  // ---------------- checking helpers ----------------
  int tests = 0, fails = 0;
  int rbase, fbase, rsp_cyc;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] tms_seq(input int base, input int n);
    logic [191:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = tms_log[base + i];
    return r;
  endfunction

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] len, input logic [191:0] d);
    int n = 0;
    bus.cmd_type  = t;
    bus.cmd_len   = len;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin step(); n++; end
    if (!bus.cmd_ready) chk("accept_timeout", {191'b0, bus.cmd_ready}, 192'd1);
    rbase = rise_total;
    fbase = fall_total;
    @(posedge sysclk);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 5000) begin step(); n++; end
    rsp_cyc = cyc;
    chk({tag, "_rsp_valid"}, {191'b0, bus.rsp_valid}, 192'd1);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  logic [191:0] rnd, held;
  bit           stable;
  int           r0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bnd_cap       = {2'b10, {5{32'hA5C3_0F96}}};
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    #2 trst = 1'b0;
    step(); step();

    // Reset values
    chk("reset_pins", {186'b0, tck, tms, tdi, bus.cmd_ready, bus.rsp_valid, busy}, 192'b111100);
    chk("reset_rsp_data", bus.rsp_data, '0);
    trst = 1'b1;
    step(); step();

    // 1: RESET command
    send(2'd0, 8'd0, '1);
    wait_rsp("t1");
    chk("t1_tck_count", rise_total - rbase, 6);
    chk("t1_tms_seq", tms_seq(rbase, 6), 192'b011111);
    chk("t1_tck_period", rise_cyc[rbase + 5] - rise_cyc[rbase + 4], 8);
    chk("t1_first_fall", fall_cyc[fbase] - acc_cyc, 4);
    chk("t1_rsp_latency", rsp_cyc - rise_cyc[rbase + 5], 1);
    chk("t1_done_pins", {188'b0, busy, tck, tms, tdi}, 192'b0101);
    chk("t1_rsp_data", bus.rsp_data, '0);
    chk("t1_tap_rti", tap_st, RTI);
    finish_rsp();
    chk("t1_ready_after", {191'b0, bus.cmd_ready}, 192'd1);

    // 2: IR scan, 3 bits of 3'b010
    send(2'd1, 8'd2, 192'b010);
    wait_rsp("t2");
    chk("t2_tck_count", rise_total - rbase, 9);
    chk("t2_tms_seq", tms_seq(rbase, 9), 192'b011000011);
    chk("t2_tdi_shift", {tdi_log[rbase + 6], tdi_log[rbase + 5], tdi_log[rbase + 4]}, 192'b010);
    chk("t2_tdi_idle", {tdi_log[rbase + 8], tdi_log[rbase + 7], tdi_log[rbase + 3],
                        tdi_log[rbase + 2], tdi_log[rbase + 1], tdi_log[rbase]}, 192'b111111);
    chk("t2_rsp_data", bus.rsp_data, 192'b001);
    chk("t2_tap_ir", ir, 4'b0100);
    finish_rsp();

    // 3: SAMPLE/PRELOAD then 162-bit boundary DR scan
    send(2'd1, 8'd3, {188'b0, SAMPLE});
    wait_rsp("t3ir");
    chk("t3_ir_capture", bus.rsp_data, 192'b0001);
    chk("t3_tap_ir", ir, SAMPLE);
    finish_rsp();
    send(2'd2, 8'd161, '0);
    wait_rsp("t3dr");
    chk("t3_tck_count", rise_total - rbase, 167);
    chk("t3_tms_pre", tms_seq(rbase, 3), 192'b001);
    chk("t3_tms_tail", {tms_log[rbase + 166], tms_log[rbase + 165], tms_log[rbase + 164],
                        tms_log[rbase + 100]}, 192'b0110);
    chk("t3_rsp_chain", bus.rsp_data[161:0], bnd_cap);
    chk("t3_rsp_upper", bus.rsp_data[191:162], '0);
    chk("t3_tap_rti", tap_st, RTI);
    finish_rsp();

    // 4: loopback, 1 bit, 192 bits, and clamped length
    loopback = 1'b1;
    for (int i = 0; i < 6; i++) rnd[i*32 +: 32] = $urandom;
    send(2'd2, 8'd0, rnd);
    wait_rsp("t4a");
    chk("t4_len1_count", rise_total - rbase, 6);
    chk("t4_len1_data", bus.rsp_data, {191'b0, rnd[0]});
    finish_rsp();
    send(2'd2, 8'd191, rnd);
    wait_rsp("t4b");
    chk("t4_len192_count", rise_total - rbase, 197);
    chk("t4_len192_data", bus.rsp_data, rnd);
    finish_rsp();
    send(2'd2, 8'd255, ~rnd);
    wait_rsp("t4c");
    chk("t4_clamp_count", rise_total - rbase, 197);
    chk("t4_clamp_data", bus.rsp_data, ~rnd);
    finish_rsp();

    // 5: response held with rsp_ready low while a new command is offered
    send(2'd2, 8'd15, 192'hBEEF);
    wait_rsp("t5");
    chk("t5_rsp_data", bus.rsp_data, 192'hBEEF);
    held          = bus.rsp_data;
    r0            = rise_total;
    stable        = 1'b1;
    bus.cmd_type  = 2'd1;
    bus.cmd_len   = 8'd3;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!bus.rsp_valid || bus.rsp_data !== held || bus.cmd_ready || busy) stable = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    chk("t5_hold_stable", {191'b0, stable}, 192'd1);
    chk("t5_no_tck", rise_total - r0, 0);
    finish_rsp();
    step(); step();
    chk("t5_no_new_cmd", {190'b0, busy, bus.cmd_ready}, 192'b01);

    // 6: trst mid-shift aborts, then RESET works
    loopback = 1'b0;
    send(2'd2, 8'd161, '1);
    for (int n = 0; n < 500 && (rise_total - rbase) < 10; n++) step();
    chk("t6_in_shift", {191'b0, (rise_total - rbase) >= 10}, 192'd1);
    trst = 1'b0;
    #1;
    chk("t6_abort_pins", {187'b0, tck, tms, tdi, busy, bus.rsp_valid}, 192'b11100);
    chk("t6_abort_ready", {191'b0, bus.cmd_ready}, 192'd1);
    step(); step();
    trst   = 1'b1;
    r0     = rise_total;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid || busy) stable = 1'b0;
    end
    chk("t6_no_rsp", {191'b0, stable}, 192'd1);
    chk("t6_no_tck", rise_total - r0, 0);
    send(2'd3, 8'd7, '0);
    wait_rsp("t6r");
    chk("t6_reset_count", rise_total - rbase, 6);
    chk("t6_reset_tms", tms_seq(rbase, 6), 192'b011111);
    chk("t6_reset_rsp", bus.rsp_data, '0);
    chk("t6_tap_rti", tap_st, RTI);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
